// File: rtl/dual_issue_slotter.sv
// rtl/dual_issue_slotter.sv - in-order issue queue steering instruction pairs to ALU and memory slots
//
// Purpose: buffers fetched instruction pairs in a DEPTH-entry circular queue and each
// cycle issues up to one ALU/branch instruction (slot A) and one load/store (slot M)
// from the queue head. The head instruction always issues. The instruction behind it
// issues alongside only if it targets the other slot, the head is not a branch, and
// there is no RAW or WAW hazard between the two. All slot outputs are registered.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid0/1, in_instr0/1    fetched pair, instr0 older; valid1 only with valid0
//   in_ready                    queue can accept two instructions this cycle
//   stall                       hold slot outputs and queue head; enqueue still allowed
//   flush                       empty the queue and clear both slots
//   out_alu_instr/_valid        slot A instruction (0 when empty) and its valid
//   out_mem_instr/_valid        slot M instruction (0 when empty) and its valid
//   out_opcode/out_opcode1      top six bits of slot A / slot M instructions
module dual_issue_slotter #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid0,
  input  logic         in_valid1,
  input  logic [W-1:0] in_instr0,
  input  logic [W-1:0] in_instr1,
  output logic         in_ready,
  input  logic         stall,
  input  logic         flush,
  output logic [W-1:0] out_alu_instr,
  output logic [W-1:0] out_mem_instr,
  output logic         out_alu_valid,
  output logic         out_mem_valid,
  output logic [5:0]   out_opcode,
  output logic [5:0]   out_opcode1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    case (op)
      OP_ADD:        return rd;
      OP_ADDI, OP_LW: return rt;
      default:       return 5'd0;
    endcase
  endfunction

  function automatic logic reads_rs(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_ADDI) || (op == OP_LW);
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  out_alu_instr_q, out_alu_instr_d, out_mem_instr_q, out_mem_instr_d;
  logic          out_alu_valid_q, out_alu_valid_d, out_mem_valid_q, out_mem_valid_d;

  logic [W-1:0]  head, nxt;
  logic [4:0]    dest_h, dest_n;
  logic          raw_hit, waw_hit, pair_ok;
  logic [1:0]    enq, deq;

  assign head = mem_q[rd_ptr_q];
  assign nxt  = mem_q[rd_ptr_q + AW'(1)];

  assign dest_h = dest_of(head[31:26], head[20:16], head[15:11]);
  assign dest_n = dest_of(nxt[31:26], nxt[20:16], nxt[15:11]);

  // Register 0 never carries a dependency, so a zero dest suppresses both hazards.
  assign raw_hit = (dest_h != 5'd0) &&
                   ((reads_rs(nxt[31:26]) && (nxt[25:21] == dest_h)) ||
                    (reads_rt(nxt[31:26]) && (nxt[20:16] == dest_h)));
  assign waw_hit = (dest_h != 5'd0) && (dest_n != 5'd0) && (dest_h == dest_n);

  assign pair_ok = (count_q >= CW'(2)) &&
                   (is_mem(head[31:26]) != is_mem(nxt[31:26])) &&
                   !is_branch(head[31:26]) && !raw_hit && !waw_hit;

  // Depends on the registered count only, so upstream sees a stable ready all cycle.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    mem_d           = mem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    out_alu_instr_d = out_alu_instr_q;
    out_mem_instr_d = out_mem_instr_q;
    out_alu_valid_d = out_alu_valid_q;
    out_mem_valid_d = out_mem_valid_q;
    enq             = 2'd0;
    deq             = 2'd0;

    if (flush) begin
      count_d         = '0;
      rd_ptr_d        = wr_ptr_q;
      out_alu_instr_d = '0;
      out_mem_instr_d = '0;
      out_alu_valid_d = 1'b0;
      out_mem_valid_d = 1'b0;
    end else begin
      if (!stall) begin
        out_alu_instr_d = '0;
        out_mem_instr_d = '0;
        out_alu_valid_d = 1'b0;
        out_mem_valid_d = 1'b0;
        if (count_q != '0) begin
          deq = pair_ok ? 2'd2 : 2'd1;
          if (is_mem(head[31:26])) begin
            out_mem_instr_d = head;
            out_mem_valid_d = 1'b1;
            if (pair_ok) begin
              out_alu_instr_d = nxt;
              out_alu_valid_d = 1'b1;
            end
          end else begin
            out_alu_instr_d = head;
            out_alu_valid_d = 1'b1;
            if (pair_ok) begin
              out_mem_instr_d = nxt;
              out_mem_valid_d = 1'b1;
            end
          end
        end
      end

      if (in_ready && in_valid0) begin
        mem_d[wr_ptr_q] = in_instr0;
        enq             = 2'd1;
        if (in_valid1) begin
          mem_d[wr_ptr_q + AW'(1)] = in_instr1;
          enq                      = 2'd2;
        end
      end

      wr_ptr_d = wr_ptr_q + AW'(enq);
      rd_ptr_d = rd_ptr_q + AW'(deq);
      count_d  = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      out_alu_instr_q <= '0;
      out_mem_instr_q <= '0;
      out_alu_valid_q <= 1'b0;
      out_mem_valid_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      out_alu_instr_q <= out_alu_instr_d;
      out_mem_instr_q <= out_mem_instr_d;
      out_alu_valid_q <= out_alu_valid_d;
      out_mem_valid_q <= out_mem_valid_d;
    end
  end

  assign out_alu_instr = out_alu_instr_q;
  assign out_mem_instr = out_mem_instr_q;
  assign out_alu_valid = out_alu_valid_q;
  assign out_mem_valid = out_mem_valid_q;
  assign out_opcode    = out_alu_instr_q[W-1 -: 6];
  assign out_opcode1   = out_mem_instr_q[W-1 -: 6];

endmodule

// File: tb/tb_dual_issue_slotter.sv
// tb/tb_dual_issue_slotter.sv - self-checking bench for dual_issue_slotter
module tb_dual_issue_slotter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [31:0] in_instr0 = '0, in_instr1 = '0;
  logic        in_ready;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] out_alu_instr, out_mem_instr;
  logic        out_alu_valid, out_mem_valid;
  logic [5:0]  out_opcode, out_opcode1;

  always #5 clk = ~clk;

  dual_issue_slotter #(.DEPTH(4), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_instr0(in_instr0), .in_instr1(in_instr1),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .out_alu_instr(out_alu_instr), .out_mem_instr(out_mem_instr),
    .out_alu_valid(out_alu_valid), .out_mem_valid(out_mem_valid),
    .out_opcode(out_opcode), .out_opcode1(out_opcode1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: program-order queue plus the expected slot contents.
  logic [31:0] q[$];
  logic [31:0] ea = '0, em = '0;
  logic        eav = 1'b0, emv = 1'b0;

  function automatic logic [31:0] mk_add(input int rd, rs, rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, rt, imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic bit m_is_mem(input logic [31:0] x);
    return x[31:26] inside {6'h23, 6'h2B};
  endfunction

  function automatic bit m_is_br(input logic [31:0] x);
    return x[31:26] inside {6'h04, 6'h05};
  endfunction

  function automatic int m_dest(input logic [31:0] x);
    if (x[31:26] == 6'h00) return int'(x[15:11]);
    if (x[31:26] inside {6'h08, 6'h23}) return int'(x[20:16]);
    return 0;
  endfunction

  function automatic int m_src1(input logic [31:0] x);
    return (x[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h23}) ? int'(x[25:21]) : 0;
  endfunction

  function automatic int m_src2(input logic [31:0] x);
    return (x[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05}) ? int'(x[20:16]) : 0;
  endfunction

  function automatic bit m_can_pair(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = m_dest(a);
    if (m_is_mem(a) == m_is_mem(b)) return 0;
    if (m_is_br(a)) return 0;
    if (d != 0 && (d == m_src1(b) || d == m_src2(b))) return 0;
    if (d != 0 && d == m_dest(b)) return 0;
    return 1;
  endfunction

  task automatic model_edge(input logic v0, v1, input logic [31:0] i0, i1, input logic st, fl);
    bit ready;
    bit pr;
    logic [31:0] h;
    if (fl) begin
      q.delete();
      ea = '0; em = '0; eav = 0; emv = 0;
      return;
    end
    ready = (q.size() <= 2);
    if (!st) begin
      ea = '0; em = '0; eav = 0; emv = 0;
      if (q.size() > 0) begin
        h  = q[0];
        pr = (q.size() >= 2) && m_can_pair(h, q[1]);
        if (m_is_mem(h)) begin
          em = h; emv = 1;
          if (pr) begin ea = q[1]; eav = 1; end
        end else begin
          ea = h; eav = 1;
          if (pr) begin em = q[1]; emv = 1; end
        end
        void'(q.pop_front());
        if (pr) void'(q.pop_front());
      end
    end
    if (ready && v0) begin
      q.push_back(i0);
      if (v1) q.push_back(i1);
    end
  endtask

  task automatic step(input logic v0, v1, input logic [31:0] i0, i1, input logic st, fl);
    in_valid0 = v0; in_valid1 = v1; in_instr0 = i0; in_instr1 = i1;
    stall = st; flush = fl;
    @(posedge clk);
    model_edge(v0, v1, i0, i1, st, fl);
    #1;
    in_valid0 = 0; in_valid1 = 0; stall = 0; flush = 0;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({out_alu_valid, out_mem_valid, out_alu_instr, out_mem_instr, out_opcode, out_opcode1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h/%h v%b%b, want all zero", out_alu_instr, out_mem_instr, out_alu_valid, out_mem_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_pair_add_lw;
    logic [31:0] a, l;
    a = mk_add(3, 1, 2);
    l = mk_i(6'h23, 5, 4, 0);
    step(1, 1, a, l, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if ({out_alu_valid, out_mem_valid, out_opcode, out_opcode1, out_alu_instr, out_mem_instr} !==
        {1'b1, 1'b1, 6'h00, 6'h23, a, l}) begin
      miscompares++;
      $display("FAIL pair_add_lw: got v%b%b op %h/%h %h/%h, want v11 op 00/23 %h/%h",
               out_alu_valid, out_mem_valid, out_opcode, out_opcode1, out_alu_instr, out_mem_instr, a, l);
    end
  endtask

  task automatic test_addi_sw;
    logic [31:0] ai, s;
    logic [31:0] want_a[3];
    logic [31:0] want_m[3];
    ai = mk_i(6'h08, 0, 4, 1);
    s  = mk_i(6'h2B, 6, 4, 0);
    want_a = '{ai, 32'h0, 32'h0};
    want_m = '{32'h0, s, 32'h0};
    step(1, 1, ai, s, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if (out_alu_instr !== want_a[k] || out_mem_instr !== want_m[k] ||
          out_alu_valid !== (want_a[k] != 0) || out_mem_valid !== (want_m[k] != 0)) begin
        miscompares++;
        $display("FAIL addi_sw[%0d]: got %h/%h v%b%b, want %h/%h", k, out_alu_instr, out_mem_instr,
                 out_alu_valid, out_mem_valid, want_a[k], want_m[k]);
      end
    end
  endtask

  task automatic test_back_to_back_adds;
    logic [31:0] a1, a2;
    logic [31:0] want[2];
    a1 = mk_add(3, 1, 2);
    a2 = mk_add(5, 6, 7);
    want = '{a1, a2};
    step(1, 1, a1, a2, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if (out_alu_instr !== want[k] || out_alu_valid !== 1'b1 || out_mem_valid !== 1'b0 ||
          out_mem_instr !== 32'h0) begin
        miscompares++;
        $display("FAIL two_adds[%0d]: got %h/%h v%b%b, want %h/0 v10", k, out_alu_instr,
                 out_mem_instr, out_alu_valid, out_mem_valid, want[k]);
      end
    end
  endtask

  task automatic test_beq_lw_flush;
    logic [31:0] b, l;
    b = mk_i(6'h04, 1, 2, 4);
    l = mk_i(6'h23, 8, 7, 0);
    step(1, 1, b, l, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    vectors++;
    if (out_alu_instr !== b || out_alu_valid !== 1'b1 || out_mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_alone: got %h v%b%b, want %h v10", out_alu_instr, out_alu_valid, out_mem_valid, b);
    end
    // Flush with a new pair offered: the pair must be dropped too.
    step(1, 1, mk_add(9, 1, 1), mk_add(10, 1, 1), 0, 1);
    vectors++;
    if ({out_alu_valid, out_mem_valid, out_alu_instr, out_mem_instr} !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: got %h/%h v%b%b rdy%b, want zero rdy1", out_alu_instr, out_mem_instr,
               out_alu_valid, out_mem_valid, in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if ({out_alu_valid, out_mem_valid, out_alu_instr, out_mem_instr} !== '0) begin
        miscompares++;
        $display("FAIL flush_no_stale[%0d]: got %h/%h v%b%b, want zero", k, out_alu_instr,
                 out_mem_instr, out_alu_valid, out_mem_valid);
      end
    end
  endtask

  task automatic test_stall_fill;
    logic [31:0] a0, a1, a2, a3;
    logic [31:0] want[4];
    a0 = mk_add(11, 1, 2);
    a1 = mk_add(12, 1, 2);
    a2 = mk_add(13, 1, 2);
    a3 = mk_add(14, 1, 2);
    want = '{a1, a2, a3, 32'h0};
    step(1, 0, a0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, a1, a2, 1, 0);
    vectors++;
    if (in_ready !== 1'b1 || out_alu_instr !== a0) begin
      miscompares++;
      $display("FAIL stall_two: got rdy%b alu %h, want rdy1 alu %h", in_ready, out_alu_instr, a0);
    end
    step(1, 0, a3, 0, 1, 0);
    vectors++;
    if (in_ready !== 1'b0 || out_alu_instr !== a0 || out_alu_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_full: got rdy%b alu %h v%b, want rdy0 alu %h v1", in_ready, out_alu_instr,
               out_alu_valid, a0);
    end
    // Offered while full: must not be stored.
    step(1, 1, mk_add(20, 1, 2), mk_add(21, 1, 2), 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if (out_alu_instr !== want[k] || out_alu_valid !== (want[k] != 0) || out_mem_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_drain[%0d]: got %h v%b%b, want %h", k, out_alu_instr, out_alu_valid,
                 out_mem_valid, want[k]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    step(1, 1, mk_add(1, 2, 3), mk_add(4, 5, 6), 0, 0);
    step(1, 1, mk_add(7, 1, 2), mk_add(8, 1, 2), 0, 0);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    ea = '0; em = '0; eav = 0; emv = 0;
    vectors++;
    if ({out_alu_valid, out_mem_valid, out_alu_instr, out_mem_instr} !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: got %h/%h v%b%b rdy%b, want zero rdy1", out_alu_instr, out_mem_instr,
               out_alu_valid, out_mem_valid, in_ready);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vectors++;
      if ({out_alu_valid, out_mem_valid, out_alu_instr, out_mem_instr} !== '0) begin
        miscompares++;
        $display("FAIL reset_no_stale[%0d]: got %h/%h v%b%b", k, out_alu_instr, out_mem_instr,
                 out_alu_valid, out_mem_valid);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    r = $urandom_range(0, 6);
    case (r)
      0: return mk_add($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      1: return mk_i(6'h08, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
      2: return mk_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), 8);
      3: return mk_i(6'h05, $urandom_range(0, 3), $urandom_range(0, 3), 8);
      4: return mk_i(6'h23, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 64));
      5: return mk_i(6'h2B, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 64));
      default: return mk_i(6'h0F, $urandom_range(0, 3), $urandom_range(0, 3), 1);
    endcase
  endfunction

  task automatic test_random;
    logic v0, v1, st, fl;
    logic [31:0] i0, i1;
    // Drop leftovers from earlier tests so model and DUT start from the same empty state.
    step(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = v0 && ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 19) == 0);
      i0 = rand_instr();
      i1 = rand_instr();
      vectors++;
      if (in_ready !== (q.size() <= 2)) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, q.size() <= 2);
      end
      step(v0, v1, i0, i1, st, fl);
      vectors++;
      if (out_alu_instr !== ea || out_mem_instr !== em || out_alu_valid !== eav ||
          out_mem_valid !== emv || out_opcode !== ea[31:26] || out_opcode1 !== em[31:26]) begin
        miscompares++;
        $display("FAIL rand_slots[%0d]: got %h/%h v%b%b, want %h/%h v%b%b", n, out_alu_instr,
                 out_mem_instr, out_alu_valid, out_mem_valid, ea, em, eav, emv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair_add_lw();
    test_addi_sw();
    test_back_to_back_adds();
    test_beq_lw_flush();
    test_stall_fill();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
